mfe_led7seg_74hc595_receiver: RTL and testbench
===============================================

Name: mfe_led7seg_74hc595_receiver

Overview:
- Receive end of the 74HC595 LED7seg serial link: samples sclk/rclk/dio from a 74HC595-style driver and rebuilds each latched 16-bit character.
- Decodes the one-hot digit-position field and writes the segment byte into a DIG_NUM-digit frame buffer.
- Flags a complete frame once every digit has been refreshed.
- Used as an on-FPGA loopback checker and as a display model in system benches; synthesizable.

Parameters:
- DIG_NUM, 8: number of digits; width of the one-hot position field.
- SEG_NUM, 8: segment bits per digit.
- SYNC_STAGES, 2: synchronizer depth on sclk/rclk/dio; range 2..4.
- Derived, not overridable: CHA_WIDTH = DIG_NUM+SEG_NUM; DAT_WIDTH = DIG_NUM*SEG_NUM; CNT_WIDTH = clogb2(CHA_WIDTH+1).

Ports:
- clk, in, 1: system clock; must be at least 4x the sclk frequency.
- rst, in, 1: asynchronous, active-low reset.
- sclk, in, 1: shift clock from the driver; asynchronous to clk.
- rclk, in, 1: latch clock from the driver; asynchronous to clk.
- dio, in, 1: serial data, MSB first.
- char, out, CHA_WIDTH: last latched word, laid out {seg[SEG_NUM-1:0], pos[DIG_NUM-1:0]}.
- char_vld, out, 1: 1-cycle pulse when char updates.
- dat, out, DAT_WIDTH: frame buffer; digit i occupies dat[SEG_NUM*(i+1)-1 : SEG_NUM*i].
- vld, out, 1: 1-cycle pulse when a frame completes.
- err, out, 1: 1-cycle pulse on a bad latched word.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; shift register, bit counter, digit mask, frame register and synchronizer flops all 0.
- Input sampling:
  - sclk, rclk and dio each pass through SYNC_STAGES flops.
  - A rise is synced & ~synced_d.
  - Requirement on the driver: sclk/rclk high and low times each ≥ 2 clk periods; dio stable ≥ SYNC_STAGES+1 clk periods around each sclk rise.
- Shift, on each sclk rise:
  - sh <= {sh[CHA_WIDTH-2:0], dio_sync}.
  - bitcnt increments and saturates at CHA_WIDTH+1.
- Latch, on each rclk rise:
  - char <= sh; char_vld pulses; bitcnt <= 0.
  - Latency: an rclk rise first sampled at clk edge N gives char/char_vld at edge N+SYNC_STAGES.
- Simultaneous sclk and rclk rise in the same cycle (74HC595 semantics):
  - char takes the pre-shift sh; the shift still occurs; bitcnt <= 1.
- Decode stage, one cycle after char_vld:
  - Valid word: bitcnt at latch == CHA_WIDTH and pos has exactly one bit set (bit i).
    - Write seg into the digit-i field of the frame; set mask[i].
    - If mask becomes all ones: dat <= updated frame, vld pulses, mask <= 0.
  - Invalid word: pos == 0, pos with ≥2 bits set, or bitcnt at latch != CHA_WIDTH.
    - err pulses; no frame or mask update; char is still presented.
- Digits may arrive in any order. A repeated digit overwrites its field and does not advance completion.
- dat holds the last complete frame. It changes only together with vld, never on partial updates.
- An rclk rise without any prior shifts latches the current sh (possibly stale) and err pulses (bitcnt=0).
- No back-pressure: every rclk rise produces exactly one char_vld.

Decomposition:
- Package mfe_led7seg_pkg holds:
  - clogb2;
  - the CHA_WIDTH/DAT_WIDTH derivation;
  - the field offsets POS_LSB=0 and SEG_LSB=DIG_NUM;
  - the default DIG_NUM/SEG_NUM.
- Sub-module mfe_sync_edge (parameter SYNC_STAGES; outputs sync level and rise pulse), instantiated for sclk, rclk and dio (dio uses the level output only).

Test Plan:
1. Single character: shift 16'hA504 MSB first, then rclk → char=16'hA504, char_vld one cycle, err=0, vld=0, frame digit 2 = 8'hA5 held internally (dat still 0).
2. Full frame: digits 0..7 with seg 8'h10+i → vld pulse exactly once after the 8th word; dat = 64'h17161514_13121110; mask clears; the next frame needs 8 new digits.
3. Out-of-order with a repeat: send digits 7,3,3(new value 8'hFF),0,1,2,4,5,6 → single vld after the last word; digit-3 field = 8'hFF.
4. Bad position: latch pos=8'h00, then pos=8'h81 → err pulses twice; no vld; dat unchanged.
5. Short word: 12 sclk pulses, then rclk → err pulse; char = low 12 bits shifted in, on top of prior sh contents; no frame update.
6. Edge cases:
   - Same-cycle sclk/rclk rises → char = pre-shift value.
   - rst asserted low mid-shift (after 9 bits), then a full valid frame → all outputs 0 during reset; the first post-reset frame completes normally.

Source files
------------

// File: rtl/mfe_led7seg_pkg.sv
// Shared sizing helpers and field layout for the 74HC595 LED7seg receiver.
// A character word is {seg, pos}; the frame packs digit i at SEG_NUM*i.
package mfe_led7seg_pkg;

  localparam int DIG_NUM_DEF = 8;
  localparam int SEG_NUM_DEF = 8;
  localparam int POS_LSB     = 0;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clogb2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res++;
    end
    return res;
  endfunction

  function automatic int cha_width(input int dig_num, input int seg_num);
    return dig_num + seg_num;
  endfunction

  function automatic int dat_width(input int dig_num, input int seg_num);
    return dig_num * seg_num;
  endfunction

  function automatic int seg_lsb(input int dig_num);
    return dig_num;
  endfunction

endpackage

// File: rtl/mfe_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with a rising-edge
// pulse taken from the synchronized level.
module mfe_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   level_dly_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], d_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q      <= '0;
      level_dly_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      level_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~level_dly_q;

endmodule

// File: rtl/mfe_led7seg_74hc595_receiver.sv
// Receive side of the 74HC595 LED7seg link: rebuilds latched characters,
// decodes the one-hot digit position and assembles complete display frames.
module mfe_led7seg_74hc595_receiver
  import mfe_led7seg_pkg::*;
#(
  parameter int DIG_NUM     = DIG_NUM_DEF,
  parameter int SEG_NUM     = SEG_NUM_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                       clk_i,
  input  logic                                       rst_n_i,
  input  logic                                       sclk_i,
  input  logic                                       rclk_i,
  input  logic                                       dio_i,
  output logic [cha_width(DIG_NUM, SEG_NUM)-1:0]     char_o,
  output logic                                       char_vld_o,
  output logic [dat_width(DIG_NUM, SEG_NUM)-1:0]     dat_o,
  output logic                                       vld_o,
  output logic                                       err_o
);

  localparam int CHA_WIDTH = cha_width(DIG_NUM, SEG_NUM);
  localparam int DAT_WIDTH = dat_width(DIG_NUM, SEG_NUM);
  localparam int CNT_WIDTH = clogb2(CHA_WIDTH + 1);
  localparam int SEG_LSB   = seg_lsb(DIG_NUM);

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CHA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT  = CNT_WIDTH'(CHA_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [DIG_NUM-1:0]   POS_ONE  = DIG_NUM'(1);

  logic sclk_rise;
  logic rclk_rise;
  logic dio_lvl;
  logic sclk_lvl_unused;
  logic rclk_lvl_unused;
  logic dio_rise_unused;

  mfe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (sclk_i),
    .level_o (sclk_lvl_unused),
    .rise_o  (sclk_rise)
  );

  mfe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rclk (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (rclk_i),
    .level_o (rclk_lvl_unused),
    .rise_o  (rclk_rise)
  );

  mfe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dio (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (dio_i),
    .level_o (dio_lvl),
    .rise_o  (dio_rise_unused)
  );

  logic [CHA_WIDTH-1:0] sh_q,        sh_d;
  logic [CNT_WIDTH-1:0] bitcnt_q,    bitcnt_d;
  logic [CNT_WIDTH-1:0] bitcnt_lat_q, bitcnt_lat_d;
  logic [CHA_WIDTH-1:0] char_q,      char_d;
  logic                 char_vld_q,  char_vld_d;
  logic [DAT_WIDTH-1:0] frame_q,     frame_d;
  logic [DIG_NUM-1:0]   mask_q,      mask_d;
  logic [DAT_WIDTH-1:0] dat_q,       dat_d;
  logic                 vld_q,       vld_d;
  logic                 err_q,       err_d;

  logic [DIG_NUM-1:0]   pos_w;
  logic [SEG_NUM-1:0]   seg_w;
  logic                 pos_onehot;
  logic                 word_ok;
  logic [DAT_WIDTH-1:0] frame_upd;
  logic [DIG_NUM-1:0]   mask_upd;

  // Decode view of the word latched on the previous cycle.
  always_comb begin
    pos_w      = char_q[POS_LSB +: DIG_NUM];
    seg_w      = char_q[SEG_LSB +: SEG_NUM];
    pos_onehot = (pos_w != '0) && ((pos_w & (pos_w - POS_ONE)) == '0);
    word_ok    = pos_onehot && (bitcnt_lat_q == CNT_FULL);
    frame_upd  = frame_q;
    for (int i = 0; i < DIG_NUM; i++) begin
      if (pos_w[i]) begin
        frame_upd[SEG_NUM*i +: SEG_NUM] = seg_w;
      end
    end
    mask_upd   = mask_q | pos_w;
  end

  always_comb begin
    sh_d         = sh_q;
    bitcnt_d     = bitcnt_q;
    bitcnt_lat_d = bitcnt_lat_q;
    char_d       = char_q;
    char_vld_d   = 1'b0;
    frame_d      = frame_q;
    mask_d       = mask_q;
    dat_d        = dat_q;
    vld_d        = 1'b0;
    err_d        = 1'b0;

    if (sclk_rise) begin
      sh_d = {sh_q[CHA_WIDTH-2:0], dio_lvl};
      if (bitcnt_q != CNT_SAT) begin
        bitcnt_d = bitcnt_q + CNT_ONE;
      end
    end

    // On a coincident shift the latch still sees the pre-shift register,
    // and the shift that happened alongside counts as the first new bit.
    if (rclk_rise) begin
      char_d       = sh_q;
      char_vld_d   = 1'b1;
      bitcnt_lat_d = bitcnt_q;
      bitcnt_d     = sclk_rise ? CNT_ONE : '0;
    end

    if (char_vld_q) begin
      if (word_ok) begin
        frame_d = frame_upd;
        if (&mask_upd) begin
          dat_d  = frame_upd;
          vld_d  = 1'b1;
          mask_d = '0;
        end else begin
          mask_d = mask_upd;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh_q         <= '0;
      bitcnt_q     <= '0;
      bitcnt_lat_q <= '0;
      char_q       <= '0;
      char_vld_q   <= 1'b0;
      frame_q      <= '0;
      mask_q       <= '0;
      dat_q        <= '0;
      vld_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sh_q         <= sh_d;
      bitcnt_q     <= bitcnt_d;
      bitcnt_lat_q <= bitcnt_lat_d;
      char_q       <= char_d;
      char_vld_q   <= char_vld_d;
      frame_q      <= frame_d;
      mask_q       <= mask_d;
      dat_q        <= dat_d;
      vld_q        <= vld_d;
      err_q        <= err_d;
    end
  end

  assign char_o     = char_q;
  assign char_vld_o = char_vld_q;
  assign dat_o      = dat_q;
  assign vld_o      = vld_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_mfe_led7seg_74hc595_receiver.sv
// Bench for the LED7seg receiver: drives the serial link bit by bit and
// compares against a digit-array model of the display.
module tb_mfe_led7seg_74hc595_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        rclk = 1'b0;
  logic        dio = 1'b0;
  logic [15:0] char_o;
  logic        char_vld_o;
  logic [63:0] dat_o;
  logic        vld_o;
  logic        err_o;

  always #5 clk = ~clk;

  mfe_led7seg_74hc595_receiver dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .sclk_i     (sclk),
    .rclk_i     (rclk),
    .dio_i      (dio),
    .char_o     (char_o),
    .char_vld_o (char_vld_o),
    .dat_o      (dat_o),
    .vld_o      (vld_o),
    .err_o      (err_o)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Pulse monitor
  int          cnt_cv = 0;
  int          cnt_err = 0;
  int          cnt_vld = 0;
  int          dat_glitch = 0;
  logic [15:0] last_char = '0;
  logic [63:0] prev_dat = '0;

  always @(negedge clk) begin
    if (char_vld_o) begin
      cnt_cv++;
      last_char = char_o;
    end
    if (err_o) cnt_err++;
    if (vld_o) cnt_vld++;
    if (rst_n && (dat_o !== prev_dat) && !vld_o) dat_glitch++;
    prev_dat = dat_o;
  end

  // Reference model: display as an array of digits
  logic [15:0] m_sh;
  int          m_cnt;
  logic [7:0]  m_frame [8];
  bit          m_seen  [8];
  logic [63:0] m_dat;

  task automatic model_reset();
    m_sh  = '0;
    m_cnt = 0;
    m_dat = '0;
    for (int i = 0; i < 8; i++) begin
      m_frame[i] = '0;
      m_seen[i]  = 1'b0;
    end
  endtask

  task automatic model_shift(input bit b);
    m_sh  = {m_sh[14:0], b};
    m_cnt = (m_cnt < 17) ? m_cnt + 1 : 17;
  endtask

  task automatic shift_bit(input bit b);
    dio = b;
    repeat (3) @(negedge clk);
    sclk = 1'b1;
    model_shift(b);
    repeat (3) @(negedge clk);
    sclk = 1'b0;
  endtask

  // Latch (optionally with a coincident shift) and compare all outputs.
  task automatic latch_chk(input string tag, input bit with_sclk, input bit b);
    int          cv0, e0, v0, lat_cnt, ones, idx;
    logic [15:0] exp_char;
    logic [7:0]  pos, seg;
    bit          valid, exp_vld, all_seen;
    cv0 = cnt_cv; e0 = cnt_err; v0 = cnt_vld;
    exp_char = m_sh;
    lat_cnt  = m_cnt;
    if (with_sclk) begin
      dio = b;
      repeat (3) @(negedge clk);
      sclk = 1'b1;
      rclk = 1'b1;
      m_sh  = {m_sh[14:0], b};
      m_cnt = 1;
    end else begin
      rclk = 1'b1;
      m_cnt = 0;
    end
    repeat (3) @(negedge clk);
    rclk = 1'b0;
    sclk = 1'b0;
    repeat (7) @(negedge clk);

    pos = exp_char[7:0];
    seg = exp_char[15:8];
    ones = 0;
    idx = 0;
    for (int i = 0; i < 8; i++) if (pos[i]) begin ones++; idx = i; end
    valid   = (lat_cnt == 16) && (ones == 1);
    exp_vld = 1'b0;
    if (valid) begin
      m_frame[idx] = seg;
      m_seen[idx]  = 1'b1;
      all_seen = 1'b1;
      for (int i = 0; i < 8; i++) if (!m_seen[i]) all_seen = 1'b0;
      if (all_seen) begin
        for (int i = 0; i < 8; i++) begin
          m_dat[8*i +: 8] = m_frame[i];
          m_seen[i] = 1'b0;
        end
        exp_vld = 1'b1;
      end
    end
    chk({tag, "_cvld"}, 64'(cnt_cv - cv0), 64'(1));
    chk({tag, "_char"}, 64'(last_char), 64'(exp_char));
    chk({tag, "_err"},  64'(cnt_err - e0), 64'(!valid));
    chk({tag, "_vld"},  64'(cnt_vld - v0), 64'(exp_vld));
    chk({tag, "_dat"},  dat_o, m_dat);
  endtask

  task automatic send_word(input string tag, input logic [15:0] w, input int nbits);
    logic [31:0] wx;
    wx = {16'h0, w};
    for (int i = nbits - 1; i >= 0; i--) shift_bit(wx[i]);
    latch_chk(tag, 1'b0, 1'b0);
  endtask

  function automatic logic [15:0] mk(input int d, input logic [7:0] s);
    logic [7:0] p;
    p = 8'(1 << d);
    return {s, p};
  endfunction

  initial begin
    int          order [9];
    logic [15:0] w;
    int          kind;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_char", 64'(char_o), 64'h0);
    chk("rst_cvld", 64'(char_vld_o), 64'h0);
    chk("rst_dat", dat_o, 64'h0);
    chk("rst_vld_err", 64'({vld_o, err_o}), 64'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single character
    send_word("t1", 16'hA504, 16);

    // Full frame in order
    for (int i = 0; i < 8; i++) send_word("t2", mk(i, 8'(8'h10 + i)), 16);
    chk("t2_dat_const", dat_o, 64'h17161514_13121110);

    // Out of order with repeated digit
    order = '{7, 3, 3, 0, 1, 2, 4, 5, 6};
    for (int k = 0; k < 9; k++)
      send_word("t3", mk(order[k], (k == 2) ? 8'hFF : 8'(8'h30 + k)), 16);
    chk("t3_dig3", 64'(dat_o[31:24]), 64'hFF);

    // Bad positions
    send_word("t4_pos00", 16'h5500, 16);
    send_word("t4_pos81", 16'h6681, 16);

    // Short word, then latch with no shifts
    send_word("t5_short", 16'h0ABC, 12);
    latch_chk("t5_noshift", 1'b0, 1'b0);

    // Coincident sclk/rclk, then 15 more bits complete a word
    for (int i = 15; i >= 0; i--) begin
      w = mk(1, 8'hC3);
      shift_bit(w[i]);
    end
    latch_chk("t6_same", 1'b1, 1'b0);
    w = mk(4, 8'h5A);
    for (int i = 14; i >= 0; i--) shift_bit(w[i]);
    latch_chk("t6_after", 1'b0, 1'b0);

    // Reset mid-shift
    for (int i = 0; i < 9; i++) shift_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    dio   = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6r_char", 64'(char_o), 64'h0);
    chk("t6r_dat", dat_o, 64'h0);
    chk("t6r_pulses", 64'({char_vld_o, vld_o, err_o}), 64'h0);
    model_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 7; i >= 0; i--) send_word("t6r_frame", mk(i, 8'($urandom)), 16);

    // Random traffic
    for (int k = 0; k < 40; k++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        w = {8'($urandom), (($urandom & 1) != 0) ? 8'h00 : 8'(8'h03 << $urandom_range(0, 6))};
        send_word("rnd_badpos", w, 16);
      end else if (kind == 1) begin
        send_word("rnd_short", 16'($urandom), int'($urandom_range(1, 15)));
      end else if (kind == 2) begin
        send_word("rnd_long", 16'($urandom), int'($urandom_range(17, 20)));
      end else begin
        send_word("rnd_ok", mk(int'($urandom_range(0, 7)), 8'($urandom)), 16);
      end
    end

    chk("dat_only_with_vld", 64'(dat_glitch), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
